// File: rtl/duart_host.sv
// Host-side sequencer for one DUART channel: polls status, moves RX/TX bytes
// through one-entry holding registers and runs the counter/timer load/start/stop sequence.
module duart_host #(
  parameter logic [3:0] STATUS_ADDR = 4'h1,
  parameter logic [3:0] DATA_ADDR   = 4'h3,
  parameter logic [7:0] IMR_INIT    = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  output logic        enable,
  output logic        we,
  output logic [3:0]  addr,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  input  logic        intr_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] timer_preset,
  input  logic        timer_start,
  output logic        timer_busy,
  output logic        timer_expired
);

  localparam logic [3:0] IMR_ADDR      = 4'h5;
  localparam logic [3:0] CTU_ADDR      = 4'h6;
  localparam logic [3:0] CTL_ADDR      = 4'h7;
  localparam logic [3:0] CT_START_ADDR = 4'hE;
  localparam logic [3:0] CT_STOP_ADDR  = 4'hF;

  typedef enum logic [3:0] {
    INIT     = 4'd0,
    IDLE     = 4'd1,
    POLL     = 4'd2,
    RD_DATA  = 4'd3,
    WR_DATA  = 4'd4,
    WR_CTU   = 4'd5,
    WR_CTL   = 4'd6,
    CT_START = 4'd7,
    CT_STOP  = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic        enable_q, enable_d;
  logic        we_q, we_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tx_full_q, tx_full_d;
  logic        tx_ready_q, tx_ready_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [15:0] preset_q, preset_d;
  logic        timer_busy_q, timer_busy_d;
  logic        ct_started_q, ct_started_d;
  logic        timer_expired_q, timer_expired_d;
  logic        done_s;

  // An access completes only once it is actually presented on the bus (enable_q),
  // so the first edge after reset just launches the INIT write.
  assign done_s = clken & enable_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: begin
        if (done_s) state_d = IDLE;
        else        state_d = state_q;
      end
      IDLE: begin
        if (ct_started_q && !intr_n)            state_d = CT_STOP;
        else if (timer_busy_q && !ct_started_q) state_d = WR_CTU;
        else                                    state_d = POLL;
      end
      POLL: begin
        if (!done_s)                      state_d = state_q;
        else if (din[1] && !rx_valid_q)   state_d = RD_DATA;
        else if (din[2] && tx_full_q)     state_d = WR_DATA;
        else                              state_d = IDLE;
      end
      WR_CTU: begin
        if (done_s) state_d = WR_CTL;
        else        state_d = state_q;
      end
      WR_CTL: begin
        if (done_s) state_d = CT_START;
        else        state_d = state_q;
      end
      RD_DATA, WR_DATA, CT_START, CT_STOP: begin
        if (done_s) state_d = IDLE;
        else        state_d = state_q;
      end
      default: state_d = INIT;
    endcase
  end

  // Bus drive for the state being entered; registered so reset forces the bus quiet
  always_comb begin
    enable_d = 1'b1;
    we_d     = 1'b0;
    addr_d   = 4'h0;
    dout_d   = 8'h00;
    case (state_d)
      INIT:     begin we_d = 1'b1; addr_d = IMR_ADDR;  dout_d = IMR_INIT;       end
      IDLE:     enable_d = 1'b0;
      POLL:     addr_d = STATUS_ADDR;
      RD_DATA:  addr_d = DATA_ADDR;
      WR_DATA:  begin we_d = 1'b1; addr_d = DATA_ADDR; dout_d = tx_hold_q;      end
      WR_CTU:   begin we_d = 1'b1; addr_d = CTU_ADDR;  dout_d = preset_q[15:8]; end
      WR_CTL:   begin we_d = 1'b1; addr_d = CTL_ADDR;  dout_d = preset_q[7:0];  end
      CT_START: addr_d = CT_START_ADDR;
      CT_STOP:  addr_d = CT_STOP_ADDR;
      default:  enable_d = 1'b0;
    endcase
  end

  // TX and RX holding registers
  always_comb begin
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (state_q == WR_DATA && done_s) begin
      tx_full_d = 1'b0;
    end else if (tx_valid && tx_ready_q) begin
      tx_full_d = 1'b1;
      tx_hold_d = tx_data;
    end else begin
      tx_full_d = tx_full_q;
    end
    if (state_q == RD_DATA && done_s) begin
      rx_data_d  = din;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    tx_ready_d = ~tx_full_d;
  end

  // Counter/timer request latch and run tracking
  always_comb begin
    preset_d        = preset_q;
    timer_busy_d    = timer_busy_q;
    ct_started_d    = ct_started_q;
    timer_expired_d = 1'b0;
    if (state_q == CT_STOP && done_s) begin
      timer_busy_d    = 1'b0;
      ct_started_d    = 1'b0;
      timer_expired_d = 1'b1;
    end else if (state_q == CT_START && done_s) begin
      ct_started_d = 1'b1;
    end else if (timer_start && !timer_busy_q) begin
      timer_busy_d = 1'b1;
      preset_d     = timer_preset;
    end else begin
      timer_busy_d = timer_busy_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= INIT;
      enable_q        <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= 4'h0;
      dout_q          <= 8'h00;
      tx_hold_q       <= 8'h00;
      tx_full_q       <= 1'b0;
      tx_ready_q      <= 1'b0;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      preset_q        <= 16'h0000;
      timer_busy_q    <= 1'b0;
      ct_started_q    <= 1'b0;
      timer_expired_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      enable_q        <= enable_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      dout_q          <= dout_d;
      tx_hold_q       <= tx_hold_d;
      tx_full_q       <= tx_full_d;
      tx_ready_q      <= tx_ready_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      preset_q        <= preset_d;
      timer_busy_q    <= timer_busy_d;
      ct_started_q    <= ct_started_d;
      timer_expired_q <= timer_expired_d;
    end
  end

  assign enable        = enable_q;
  assign we            = we_q;
  assign addr          = addr_q;
  assign dout          = dout_q;
  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign timer_busy    = timer_busy_q;
  assign timer_expired = timer_expired_q;

endmodule

// File: doc/duart_host.md
DUART_HOST -- requirements
Module: duart_host

Interface
REQ-001 Parameter STATUS_ADDR, default 4'h1, meaning: DUART channel-A status register address.
REQ-002 Parameter DATA_ADDR, default 4'h3, meaning: DUART channel-A RX/TX data register address.
REQ-003 Parameter IMR_INIT, default 8'h08, meaning: value written to the interrupt mask register (4'h5) after reset.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port clken  input  1  bus-cycle strobe, shared with the DUART; a bus access completes on a clk edge where clken=1.
REQ-007 Port enable  output  1  DUART chip select.
REQ-008 Port we  output  1  DUART write strobe (1=write, 0=read).
REQ-009 Port addr  output  4  DUART register address.
REQ-010 Port dout  output  8  write data to the DUART.
REQ-011 Port din  input  8  read data from the DUART (combinational in addr).
REQ-012 Port intr_n  input  1  DUART interrupt, active-low, same clock domain.
REQ-013 Port tx_data  input  8  byte to transmit.
REQ-014 Port tx_valid  input  1  tx_data is valid.
REQ-015 Port tx_ready  output  1  one-entry TX holding register is empty.
REQ-016 Port rx_data  output  8  received byte.
REQ-017 Port rx_valid  output  1  rx_data is valid; held until it is taken.
REQ-018 Port rx_ready  input  1  consumer takes rx_data.
REQ-019 Port timer_preset  input  16  counter/timer preset.
REQ-020 Port timer_start  input  1  single-cycle request to load and start the counter/timer.
REQ-021 Port timer_busy  output  1  timer sequence in progress.
REQ-022 Port timer_expired  output  1  one-cycle pulse when the timer sequence completes.

Function
REQ-023 FSM states SHALL be INIT, IDLE, POLL, RD_DATA, WR_DATA, WR_CTU, WR_CTL, CT_START and CT_STOP.
REQ-024 Bus access rule: in every non-IDLE state, the FSM SHALL drive enable=1 and hold we, addr and dout constant until the first clk edge with clken=1. At that edge the access completes, read data is sampled from din, and the state transitions.
REQ-025 In IDLE the FSM SHALL drive enable=0, we=0, addr=0 and dout=0, and SHALL remain in IDLE for exactly one clk.
REQ-026 Register accesses per state:
  - INIT: write IMR_INIT to 4'h5.
  - POLL: read STATUS_ADDR.
  - RD_DATA: read DATA_ADDR.
  - WR_DATA: write the TX holding register to DATA_ADDR.
  - WR_CTU: write timer_preset[15:8] to 4'h6.
  - WR_CTL: write timer_preset[7:0] to 4'h7.
  - CT_START: read 4'hE.
  - CT_STOP: read 4'hF.
REQ-027 State transitions:
  - INIT -> IDLE.
  - WR_CTU -> WR_CTL -> CT_START -> IDLE.
  - RD_DATA, WR_DATA and CT_STOP -> IDLE.
REQ-028 IDLE exit priority:
  1. CT_STOP, if the timer is started and intr_n=0.
  2. WR_CTU, if a timer request is latched and not yet started.
  3. Otherwise POLL.
REQ-029 On POLL completion, with S the sampled status:
  - S[1]=1 and rx_valid=0 -> RD_DATA.
  - Else S[2]=1 and TX holding full -> WR_DATA.
  - Else IDLE.
REQ-030 RD_DATA completion SHALL load din into rx_data and set rx_valid=1 in the same edge.
REQ-031 rx_valid SHALL clear on the edge where rx_valid=1 and rx_ready=1.
REQ-032 While rx_valid=1 the block SHALL NOT read DATA_ADDR. DUART overrun behaviour is then the DUART's.
REQ-033 tx_ready SHALL equal NOT(TX holding full).
REQ-034 On an edge with tx_valid=1 and tx_ready=1, the block SHALL capture tx_data and mark the holding register full.
REQ-035 WR_DATA completion SHALL mark the TX holding register empty, so tx_ready=1 from the next cycle.
REQ-036 timer_start=1 while timer_busy=0 SHALL latch timer_preset and set timer_busy on the next edge.
REQ-037 timer_start=1 while timer_busy=1 SHALL be ignored.
REQ-038 The counter/timer is "started" from CT_START completion until CT_STOP completion.
REQ-039 CT_STOP completion SHALL clear timer_busy and pulse timer_expired for exactly one clk.
REQ-040 intr_n SHALL be ignored unless the counter/timer is started.
REQ-041 Latency: a DUART status with S[1]=1 SHALL produce rx_valid no earlier than two completed bus accesses (POLL, RD_DATA) after the POLL starts.

Reset
REQ-042 While reset=0, all outputs SHALL be 0, including tx_ready, the bus outputs, rx_valid, timer_busy and timer_expired.
REQ-043 While reset=0, the TX holding register, RX holding register and timer latch SHALL be cleared, and the FSM SHALL be in INIT.
REQ-044 Reset asserted mid-access SHALL deassert enable immediately (asynchronously); no partial access is retried.
REQ-045 After reset deasserts, the first bus access SHALL be the INIT IMR write, and tx_ready SHALL rise on the first clk edge.

Verification
REQ-046 Reset release, clken every 4th clk -> first access: enable=1, we=1, addr=4'h5, dout=8'h08; then repeated reads of addr 4'h1.
REQ-047 DUART status 8'h06 and din=8'h41 at addr 4'h3, rx_ready=0 -> exactly one read of 4'h3; rx_data=8'h41 and rx_valid=1 held; no further 4'h3 reads until rx_ready=1.
REQ-048 tx_valid with 8'h5A while status returns 8'h00 -> tx_ready=0 and no write; after status becomes 8'h0C -> one write addr=4'h3, dout=8'h5A; then tx_ready=1.
REQ-049 timer_start with preset 16'h1234 -> writes 8'h12 to 4'h6, 8'h34 to 4'h7, then a read of 4'hE; timer_busy=1. Second timer_start is ignored. intr_n=0 -> read of 4'hF, then timer_expired one-cycle pulse and timer_busy=0.
REQ-050 Reset asserted while enable=1 during a WR_DATA access -> enable=0 and tx_ready=0 immediately; after release, the INIT write occurs and the pending byte is never written.
REQ-051 Simultaneous intr_n=0 and status 8'h02 while the timer is started -> CT_STOP precedes the next POLL.
